// File: rtl/hazard_pkg.sv
// Shared types and parameter limits for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } hz_state_t;

  localparam int LOAD_STALL_MIN = 1;
  localparam int LOAD_STALL_MAX = 4;
  localparam int BR_FLUSH_MIN   = 1;
  localparam int BR_FLUSH_MAX   = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  // Counter register: async reset, sync clear, saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= {W{1'b0}};
    end else if (clr) begin
      value <= {W{1'b0}};
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + {{(W-1){1'b0}}, 1'b1};
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Sequential hazard controller: multi-cycle load-use stalls, branch flushes,
// memory-busy freezes and saturating performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BR_FLUSH_CYC   = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              ifid_uses_rt_i,
  input  logic              branch_taken_i,
  input  logic              mem_busy_i,
  input  logic              perf_clr_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  if ((LOAD_STALL_CYC < LOAD_STALL_MIN) || (LOAD_STALL_CYC > LOAD_STALL_MAX)) begin : g_bad_load
    $error("hazard_ctrl_unit: LOAD_STALL_CYC out of range");
  end
  if ((BR_FLUSH_CYC < BR_FLUSH_MIN) || (BR_FLUSH_CYC > BR_FLUSH_MAX)) begin : g_bad_br
    $error("hazard_ctrl_unit: BR_FLUSH_CYC out of range");
  end

  // The event cycle itself is the first stall/flush cycle, hence the -2 reload.
  localparam logic [1:0] LD_RELOAD = (LOAD_STALL_CYC > 1) ? 2'(LOAD_STALL_CYC - 2) : 2'd0;
  localparam logic [1:0] BR_RELOAD = (BR_FLUSH_CYC > 1) ? 2'(BR_FLUSH_CYC - 2) : 2'd0;

  hz_state_t  state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       hz;
  logic       br_evt;

  assign hz = idex_memread_i && (idex_rd_i != {REG_AW{1'b0}}) &&
              ((idex_rd_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rd_i == ifid_rt_i)));

  // State and down-counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and control outputs; priority is reset, freeze, branch, then stall.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    br_evt        = 1'b0;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    if (rst_i) begin
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
    end else if (mem_busy_i) begin
      state_nxt = state;
    end else if (branch_taken_i) begin
      br_evt       = 1'b1;
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      if (BR_FLUSH_CYC > 1) begin
        state_nxt = BR_FLUSH;
        cnt_nxt   = BR_RELOAD;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    end else begin
      case (state)
        BR_FLUSH: begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
          if (cnt != 2'd0) begin
            cnt_nxt = cnt - 2'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        LD_STALL: begin
          idex_bubble_o = 1'b1;
          if (cnt != 2'd0) begin
            cnt_nxt = cnt - 2'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        IDLE: begin
          if (hz) begin
            idex_bubble_o = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_nxt = LD_STALL;
              cnt_nxt   = LD_RELOAD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (idex_bubble_o),
    .clr   (perf_clr_i),
    .value (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (br_evt),
    .clr   (perf_clr_i),
    .value (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: two configurations share stimulus; a scoreboard queue
// holds the expected control vector for each driven cycle.
module tb_hazard_ctrl_unit;

  localparam logic [4:0] IDL = 5'b11000;  // {pc_write, ifid_write, bubble, ifid_flush, idex_flush}
  localparam logic [4:0] STL = 5'b00100;
  localparam logic [4:0] FLS = 5'b11011;
  localparam logic [4:0] FRZ = 5'b00000;

  typedef struct {
    logic [4:0] ctrl;
    bit         sel_b;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       memread = 1'b0;
  logic [4:0] rd = 5'd0, rs = 5'd0, rt = 5'd0;
  logic       uses_rt = 1'b0, br = 1'b0, busy = 1'b0, clr = 1'b0;

  logic        pcw_a, ifw_a, bub_a, iff_a, idf_a;
  logic        pcw_b, ifw_b, bub_b, iff_b, idf_b;
  logic [1:0]  scnt_a, fcnt_a;
  logic [15:0] scnt_b, fcnt_b;
  logic [4:0]  ctrl_a, ctrl_b;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  assign ctrl_a = {pcw_a, ifw_a, bub_a, iff_a, idf_a};
  assign ctrl_b = {pcw_b, ifw_b, bub_b, iff_b, idf_b};

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYC(2), .BR_FLUSH_CYC(3), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rd_i(rd),
    .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
    .branch_taken_i(br), .mem_busy_i(busy), .perf_clr_i(clr),
    .pc_write_o(pcw_a), .ifid_write_o(ifw_a), .idex_bubble_o(bub_a),
    .ifid_flush_o(iff_a), .idex_flush_o(idf_a),
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYC(4), .BR_FLUSH_CYC(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rd_i(rd),
    .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
    .branch_taken_i(br), .mem_busy_i(busy), .perf_clr_i(clr),
    .pc_write_o(pcw_b), .ifid_write_o(ifw_b), .idex_bubble_o(bub_b),
    .ifid_flush_o(iff_b), .idex_flush_o(idf_b),
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
  );

  // Scoreboard consumer: mid-cycle, compare the selected DUT against the oldest expectation.
  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = e.sel_b ? ctrl_b : ctrl_a;
      total++;
      if (act !== e.ctrl) begin
        bad++;
        $display("FAIL %s: got ctrl=%b expected %b", e.name, act, e.ctrl);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge, queue its expectation, advance.
  task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic ur, input logic b,
                       input logic bz, input logic c, input bit sel_b,
                       input logic [4:0] ctrl, input string name);
    exp_t e;
    memread = mr; rd = d; rs = s; rt = t; uses_rt = ur;
    br = b; busy = bz; clr = c;
    e.ctrl = ctrl; e.sel_b = sel_b; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input bit sel_b, input logic [4:0] ctrl, input string name);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, sel_b, ctrl, name);
  endtask

  task automatic hz_cyc(input bit sel_b, input logic [4:0] ctrl, input string name);
    drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, sel_b, ctrl, name);
  endtask

  task automatic test_reset();
    memread = 1'b0; rd = 5'd0; rs = 5'd0; rt = 5'd0;
    uses_rt = 1'b0; br = 1'b0; busy = 1'b0; clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({ctrl_a, ctrl_b} !== 10'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b/%b expected 00000/00000", ctrl_a, ctrl_b);
    end
    total++;
    if ({scnt_a, fcnt_a, scnt_b, fcnt_b} !== 36'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d %0d %0d %0d expected all 0", scnt_a, fcnt_a, scnt_b, fcnt_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_stall();
    test_reset();
    for (int i = 0; i < 3; i++) idle_cyc(1'b0, IDL, "ls_pre_idle");
    hz_cyc(1'b0, STL, "ls_cycle3");
    hz_cyc(1'b0, STL, "ls_cycle4");
    idle_cyc(1'b0, IDL, "ls_cycle5_release");
    total++;
    if (scnt_a !== 2'd2) begin
      bad++; $display("FAIL ls_stall_cnt: got %0d expected 2", scnt_a);
    end
  endtask

  task automatic test_zero_rt();
    test_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDL, "zero_reg_no_stall");
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDL, "rt_unused_no_stall");
    drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDL, "no_memread_no_stall");
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STL, "rt_used_stall");
    idle_cyc(1'b0, STL, "rt_used_stall2");
    idle_cyc(1'b0, IDL, "rt_used_release");
    total++;
    if (scnt_a !== 2'd2) begin
      bad++; $display("FAIL rt_stall_cnt: got %0d expected 2", scnt_a);
    end
  endtask

  task automatic test_branch_flush();
    test_reset();
    for (int i = 0; i < 10; i++) idle_cyc(1'b0, IDL, "br_pre_idle");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FLS, "br_cycle10");
    hz_cyc(1'b0, FLS, "br_cycle11_hz_ignored");
    idle_cyc(1'b0, FLS, "br_cycle12");
    idle_cyc(1'b0, IDL, "br_cycle13");
    total++;
    if (fcnt_a !== 2'd1) begin
      bad++; $display("FAIL br_flush_cnt: got %0d expected 1", fcnt_a);
    end
    total++;
    if (scnt_a !== 2'd0) begin
      bad++; $display("FAIL br_stall_cnt: got %0d expected 0", scnt_a);
    end
  endtask

  task automatic test_branch_during_stall();
    test_reset();
    hz_cyc(1'b1, STL, "bds_cycle0_stall");
    drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FLS, "bds_cycle1_flush");
    idle_cyc(1'b1, IDL, "bds_cycle2_idle");
    total++;
    if (scnt_b !== 16'd1) begin
      bad++; $display("FAIL bds_stall_cnt: got %0d expected 1", scnt_b);
    end
    total++;
    if (fcnt_b !== 16'd1) begin
      bad++; $display("FAIL bds_flush_cnt: got %0d expected 1", fcnt_b);
    end
  endtask

  task automatic test_freeze_clear();
    test_reset();
    for (int i = 0; i < 3; i++) idle_cyc(1'b0, IDL, "fz_pre_idle");
    hz_cyc(1'b0, STL, "fz_cycle3_stall");
    drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, "fz_cycle4_freeze");
    total++;
    if (scnt_a !== 2'd1) begin
      bad++; $display("FAIL fz_cnt_before_clr: got %0d expected 1", scnt_a);
    end
    drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, "fz_cycle5_freeze_clr");
    total++;
    if (scnt_a !== 2'd0) begin
      bad++; $display("FAIL fz_cnt_after_clr: got %0d expected 0", scnt_a);
    end
    hz_cyc(1'b0, STL, "fz_cycle6_stall");
    idle_cyc(1'b0, IDL, "fz_cycle7_release");
    total++;
    if (scnt_a !== 2'd1) begin
      bad++; $display("FAIL fz_cnt_end: got %0d expected 1", scnt_a);
    end
  endtask

  task automatic test_saturate();
    test_reset();
    for (int i = 0; i < 5; i++) begin
      hz_cyc(1'b0, STL, "sat_hz");
      idle_cyc(1'b0, STL, "sat_hold");
      idle_cyc(1'b0, IDL, "sat_idle");
      if (i == 0) begin
        total++;
        if (scnt_a !== 2'd2) begin
          bad++; $display("FAIL sat_first_event: got %0d expected 2", scnt_a);
        end
      end
    end
    total++;
    if (scnt_a !== 2'd3) begin
      bad++; $display("FAIL sat_stall_cnt: got %0d expected 3", scnt_a);
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    hz_cyc(1'b0, STL, "ar_stall");
    total++;
    if (scnt_a !== 2'd1 || bub_a !== 1'b1) begin
      bad++; $display("FAIL ar_in_stall: got cnt=%0d bubble=%b expected 1/1", scnt_a, bub_a);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ctrl_a !== 5'd0 || scnt_a !== 2'd0 || fcnt_a !== 2'd0) begin
      bad++; $display("FAIL ar_immediate: got ctrl=%b cnt=%0d/%0d expected 00000 0/0", ctrl_a, scnt_a, fcnt_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cyc(1'b0, IDL, "ar_after_release_idle");
  endtask

  initial begin
    test_reset();
    idle_cyc(1'b0, IDL, "post_reset_idle_a");
    idle_cyc(1'b1, IDL, "post_reset_idle_b");
    test_load_stall();
    test_zero_rt();
    test_branch_flush();
    test_branch_during_stall();
    test_freeze_clear();
    test_saturate();
    test_async_reset();
    @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
